// File: rtl/corelet_ctrl_pkg.sv
// rtl/corelet_ctrl_pkg.sv - shared state enum and PE-array instruction encodings for corelet_ctrl
package corelet_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_FETCH = 3'd1,
        W_KLOAD = 3'd2,
        A_FETCH = 3'd3,
        A_EXEC  = 3'd4,
        DRAIN   = 3'd5,
        DONE    = 3'd6
    } state_e;

    localparam logic [1:0] INST_IDLE  = 2'b00;
    localparam logic [1:0] INST_KLOAD = 2'b01;
    localparam logic [1:0] INST_EXEC  = 2'b10;

endpackage

// File: rtl/corelet_ctrl.sv
// rtl/corelet_ctrl.sv - tile sequencer: weight fetch/kernel load, activation fetch/execute, psum drain
module corelet_ctrl
    import corelet_ctrl_pkg::*;
#(
    parameter int col     = 8,
    parameter int row     = 8,
    parameter int addr_bw = 11,
    parameter int len_bw  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [len_bw-1:0]  n_act,
    input  logic [addr_bw-1:0] w_base,
    input  logic [addr_bw-1:0] a_base,
    input  logic [addr_bw-1:0] p_base,
    output logic               busy,
    output logic               done,
    output logic               xmem_rd,
    output logic [addr_bw-1:0] xmem_addr,
    output logic               l0_wr,
    output logic               l0_rd,
    output logic [1:0]         inst_w,
    input  logic               ofifo_valid,
    output logic               ofifo_rd,
    output logic               pmem_wr,
    output logic [addr_bw-1:0] pmem_addr
);

    // One extra bit so that cnt can reach n_act when n_act is all-ones.
    localparam int CNT_W = len_bw + 1;
    localparam logic [CNT_W-1:0] COL_C = CNT_W'(col);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    // The sequence does not depend on the row count; it only documents the array geometry.
    if (row < 1) begin : g_row_unused
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [len_bw-1:0]  n_act_q;
    logic [addr_bw-1:0] w_base_q, a_base_q, p_base_q;
    logic               l0_wr_q;
    logic               accept;
    logic [CNT_W-1:0]   n_ext, n_last;
    logic [addr_bw-1:0] cnt_addr;

    assign accept   = (state_q == IDLE) && start && (n_act != '0);
    assign n_ext    = {1'b0, n_act_q};
    assign n_last   = n_ext - ONE_C;
    assign cnt_addr = addr_bw'(cnt_q);
    assign l0_wr    = l0_wr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            n_act_q  <= '0;
            w_base_q <= '0;
            a_base_q <= '0;
            p_base_q <= '0;
            l0_wr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            l0_wr_q <= xmem_rd;
            if (accept) begin
                n_act_q  <= n_act;
                w_base_q <= w_base;
                a_base_q <= a_base;
                p_base_q <= p_base;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + ONE_C;
        busy      = 1'b1;
        done      = 1'b0;
        xmem_rd   = 1'b0;
        xmem_addr = '0;
        l0_rd     = 1'b0;
        inst_w    = INST_IDLE;
        ofifo_rd  = 1'b0;
        pmem_wr   = 1'b0;
        pmem_addr = '0;
        unique case (state_q)
            IDLE: begin
                busy  = 1'b0;
                cnt_d = '0;
                if (accept) begin
                    state_d = W_FETCH;
                end
            end
            W_FETCH: begin
                if (cnt_q < COL_C) begin
                    xmem_rd   = 1'b1;
                    xmem_addr = w_base_q + cnt_addr;
                end
                if (cnt_q == COL_C) begin
                    state_d = W_KLOAD;
                    cnt_d   = '0;
                end
            end
            W_KLOAD: begin
                l0_rd  = 1'b1;
                inst_w = INST_KLOAD;
                if (cnt_q == COL_C - ONE_C) begin
                    state_d = A_FETCH;
                    cnt_d   = '0;
                end
            end
            A_FETCH: begin
                if (cnt_q < n_ext) begin
                    xmem_rd   = 1'b1;
                    xmem_addr = a_base_q + cnt_addr;
                end
                if (cnt_q == n_ext) begin
                    state_d = A_EXEC;
                    cnt_d   = '0;
                end
            end
            A_EXEC: begin
                l0_rd  = 1'b1;
                inst_w = INST_EXEC;
                if (cnt_q == n_last) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                // Here cnt counts completed psum writes, so it doubles as the address offset.
                ofifo_rd  = ofifo_valid;
                pmem_wr   = ofifo_valid;
                pmem_addr = p_base_q + cnt_addr;
                cnt_d     = ofifo_valid ? cnt_q + ONE_C : cnt_q;
                if (ofifo_valid && (cnt_q == n_last)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule
